// File: rtl/mem_arbiter_cache.sv
// mem_arbiter_cache: round-robin arbiter for two requesters sharing one slowmem port, fronted by a
// direct-mapped write-through, write-allocate word cache.
module mem_arbiter_cache #(
  parameter int INDEXBITS = 3,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    rnotw,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          mstrobe,
  output logic          mrnotw,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic          mfc,
  input  logic [DW-1:0] mrdata,
  input  logic          flush,
  output logic [15:0]   hits,
  output logic [15:0]   misses
);
  localparam int N = 1 << INDEXBITS;
  localparam int TW = AW - INDEXBITS;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;
  state_t state_q, state_d;
  logic [1:0] ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d, mwdata_q, mwdata_d;
  logic mstrobe_q, mstrobe_d, mrnotw_q, mrnotw_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [N-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [N];
  logic [TW-1:0] tag_d [N];
  logic [DW-1:0] data_q [N];
  logic [DW-1:0] data_d [N];
  logic last_q, last_d, g_q, g_d, fpend_q, fpend_d;
  logic [15:0] hits_q, hits_d, misses_q, misses_d;
  logic [1:0] elig;
  logic gnt, take, rd, hit, do_flush;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [INDEXBITS-1:0] idx, midx;
  logic [TW-1:0] tag;
  // A port's req is still high during its own ack cycle, so it is masked there.
  assign elig = req & ~ack_q;
  assign gnt = (elig == 2'b11) ? ~last_q : elig[1];
  assign do_flush = (state_q == IDLE) && (flush || fpend_q);
  assign take = (state_q == IDLE) && (|elig) && !do_flush;
  assign a = gnt ? addr1 : addr0;
  assign wd = gnt ? wdata1 : wdata0;
  assign rd = rnotw[gnt];
  assign idx = a[INDEXBITS-1:0];
  assign tag = a[AW-1:INDEXBITS];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign midx = maddr_q[INDEXBITS-1:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q <= '0;
      rdata_q <= '0;
      mstrobe_q <= 1'b0;
      mrnotw_q <= 1'b1;
      maddr_q <= '0;
      mwdata_q <= '0;
      valid_q <= '0;
      tag_q <= '{default: '0};
      data_q <= '{default: '0};
      last_q <= 1'b1;
      g_q <= 1'b0;
      fpend_q <= 1'b0;
      hits_q <= '0;
      misses_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
      mstrobe_q <= mstrobe_d;
      mrnotw_q <= mrnotw_d;
      maddr_q <= maddr_d;
      mwdata_q <= mwdata_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
      last_q <= last_d;
      g_q <= g_d;
      fpend_q <= fpend_d;
      hits_q <= hits_d;
      misses_q <= misses_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !take ? IDLE : !rd ? WR : hit ? IDLE : RD_WAIT;
      RD_WAIT: state_d = mfc ? IDLE : RD_WAIT;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ack_d = '0;
    rdata_d = rdata_q;
    mstrobe_d = 1'b0;
    mrnotw_d = 1'b1;
    maddr_d = maddr_q;
    mwdata_d = mwdata_q;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    last_d = last_q;
    g_d = g_q;
    hits_d = hits_q;
    misses_d = misses_q;
    fpend_d = fpend_q || (flush && state_q != IDLE);
    if (do_flush) begin
      valid_d = '0;
      fpend_d = 1'b0;
    end else if (take) begin
      last_d = gnt;
      g_d = gnt;
      if (rd && hit) begin
        ack_d[gnt] = 1'b1;
        rdata_d = data_q[idx];
        hits_d = hits_q + 16'(hits_q != 16'hFFFF);
      end else if (rd) begin
        mstrobe_d = 1'b1;
        maddr_d = a;
        misses_d = misses_q + 16'(misses_q != 16'hFFFF);
      end else begin
        mstrobe_d = 1'b1;
        mrnotw_d = 1'b0;
        maddr_d = a;
        mwdata_d = wd;
        valid_d[idx] = 1'b1;
        tag_d[idx] = tag;
        data_d[idx] = wd;
      end
    end else if (state_q == RD_WAIT && mfc) begin
      valid_d[midx] = 1'b1;
      tag_d[midx] = maddr_q[AW-1:INDEXBITS];
      data_d[midx] = mrdata;
      rdata_d = mrdata;
      ack_d[g_q] = 1'b1;
    end else if (state_q == WR) begin
      ack_d[g_q] = 1'b1;
    end
  end
  assign ack = ack_q;
  assign rdata = rdata_q;
  assign mstrobe = mstrobe_q;
  assign mrnotw = mrnotw_q;
  assign maddr = maddr_q;
  assign mwdata = mwdata_q;
  assign hits = hits_q;
  assign misses = misses_q;
endmodule
